// File: rtl/datapath_ctrl_if.sv
// Control bundle between datapath_ctrl and the DataPath block.
// The master side, the controller, takes START/OPSEL and drives every datapath control.
interface datapath_ctrl_if;
  logic       START;
  logic [1:0] OPSEL;
  logic       CLR;
  logic [2:0] W;
  logic [3:0] CE;
  logic [1:0] SEL;
  logic [2:0] S;
  logic       BUSY;
  logic       DONE;

  modport master (
    input  START, OPSEL,
    output CLR, W, CE, SEL, S, BUSY, DONE
  );

  modport slave (
    output START, OPSEL,
    input  CLR, W, CE, SEL, S, BUSY, DONE
  );
endinterface

// File: rtl/datapath_ctrl.sv
// Moore sequencer for DataPath: clear, load R0..R2, accumulate R0/R1/R2 into A, write A to R2.
// All outputs decode from registered state only.
module datapath_ctrl #(
  parameter logic [2:0] OP_PASS = 3'b000,
  parameter logic [2:0] OP_ADD  = 3'b001,
  parameter logic [2:0] OP_SUB  = 3'b010,
  parameter logic [2:0] OP_AND  = 3'b011,
  parameter logic [2:0] OP_OR   = 3'b100
) (
  input logic             CLK,
  input logic             CLRN,
  datapath_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    StIdle, StClear, StLoad, StPass, StAdd, StOp3, StWb, StDone
  } state_e;

  state_e     state_q, state_d;
  logic       s1_q, s2_q, s3_q;
  logic [1:0] op_q, op_d;
  logic       go;

  // START is asynchronous: two-flop synchronizer, then s3 keeps history for edge detection.
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.START;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign go = s2_q & ~s3_q;

  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      state_q <= StIdle;
      op_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      StIdle: begin
        if (go) begin
          state_d = StClear;
          op_d    = bus.OPSEL;
        end
      end
      StClear: state_d = StLoad;
      StLoad:  state_d = StPass;
      StPass:  state_d = StAdd;
      StAdd:   state_d = StOp3;
      StOp3:   state_d = StWb;
      StWb:    state_d = StDone;
      // Leaving DONE only on release forces a fresh START edge for the next run.
      StDone:  if (!s2_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.CLR  = 1'b0;
    bus.W    = 3'b000;
    bus.CE   = 4'b0000;
    bus.SEL  = 2'b00;
    bus.S    = OP_PASS;
    bus.BUSY = 1'b0;
    bus.DONE = 1'b0;
    case (state_q)
      StClear: begin
        bus.CLR  = 1'b1;
        bus.BUSY = 1'b1;
      end
      StLoad: begin
        bus.CE   = 4'b0111;
        bus.BUSY = 1'b1;
      end
      StPass: begin
        bus.CE   = 4'b1000;
        bus.BUSY = 1'b1;
      end
      StAdd: begin
        bus.SEL  = 2'b01;
        bus.S    = OP_ADD;
        bus.CE   = 4'b1000;
        bus.BUSY = 1'b1;
      end
      StOp3: begin
        bus.SEL  = 2'b10;
        bus.CE   = 4'b1000;
        bus.BUSY = 1'b1;
        case (op_q)
          2'b00:   bus.S = OP_SUB;
          2'b01:   bus.S = OP_ADD;
          2'b10:   bus.S = OP_AND;
          default: bus.S = OP_OR;
        endcase
      end
      StWb: begin
        bus.W    = 3'b100;
        bus.CE   = 4'b0100;
        bus.BUSY = 1'b1;
      end
      StDone:  bus.DONE = 1'b1;
      default: ;
    endcase
  end

endmodule
